// File: rtl/idp_step_ctrl.sv
// idp_step_ctrl: turns each debounced step press (or auto-run timer tick) into one W_En strobe
//
// Ports:
//   clock    - system clock
//   reset    - asynchronous active-low reset
//   step_in  - weStep from the switch filter, asynchronous, level-held while pressed
//   run      - 1 = auto-run from internal timer, 0 = manual single step
//   instr_in - instruction word from board switches
//   W_En     - IDP write strobe, one clock wide per step
//   instr_q  - instruction latched for the current/last step
//   step_cnt - W_En pulses issued since reset (wraps)
//   busy     - controller is mid-step
//   hist_sel - history index, 0 = most recent
//   hist_out - selected history entry
//
// Optional feature: define STEP_HIST_EN for a 4-entry history of written instructions;
// without it hist_out is tied to 0.
module idp_step_ctrl #(
  parameter int IW      = 16,
  parameter int CNT_W   = 8,
  parameter int RUN_DIV = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_in,
  input  logic             run,
  input  logic [IW-1:0]    instr_in,
  output logic             W_En,
  output logic [IW-1:0]    instr_q,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  input  logic [1:0]       hist_sel,
  output logic [IW-1:0]    hist_out
);
  localparam int TW = $clog2(RUN_DIV);
  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, RELEASE} state_t;
  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [IW-1:0]     instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_en_q, busy_q;
  logic              tick, trig;
  assign tick = run && (tmr_q == TW'(RUN_DIV - 1));
  // In auto-run the button edge is ignored entirely, so stale edges never fire.
  assign trig = run ? tick : (s2_q & ~s3_q);
  always_comb begin
    tmr_d   = (!run || tick) ? '0 : tmr_q + TW'(1);
    state_d = state_q == IDLE    ? (trig ? CAPTURE : IDLE) :
              state_q == CAPTURE ? WRITE :
              state_q == WRITE   ? RELEASE :
              (run || !s2_q)     ? IDLE : RELEASE;
    instr_d = state_q == CAPTURE ? instr_in : instr_q;
    cnt_d   = state_q == WRITE ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      tmr_q   <= '0;
      state_q <= IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
      w_en_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= step_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      tmr_q   <= tmr_d;
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      w_en_q  <= state_d == WRITE;
      busy_q  <= state_d != IDLE;
    end
  end
  assign W_En     = w_en_q;
  assign busy     = busy_q;
  assign step_cnt = cnt_q;
`ifdef STEP_HIST_EN
  logic [IW-1:0] hist_q [4];
  logic [IW-1:0] hist_d [4];
  always_comb begin
    hist_d = hist_q;
    if (state_q == WRITE) begin
      hist_d[0] = instr_q;
      for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hist_q <= '{default: '0};
    else hist_q <= hist_d;
  end
  assign hist_out = hist_q[hist_sel];
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel;
  assign hist_out = '0;
`endif
endmodule

// File: tb/tb_idp_step_ctrl.sv
// tb_idp_step_ctrl: directed and randomized checks of idp_step_ctrl against a cycle-level reference model
module tb_idp_step_ctrl;
  localparam int IW = 16, CW = 8, RD = 8;
  logic clock = 0, reset = 0, step_in = 0, run = 0;
  logic [IW-1:0] instr_in = '0;
  logic [1:0] hist_sel = '0;
  logic W_En, busy;
  logic [IW-1:0] instr_q, hist_out;
  logic [CW-1:0] step_cnt;
  int checks = 0, failures = 0;
  int pulses = 0, ncyc = 0;
  int pt[$];
  always #5 clock = ~clock;
  idp_step_ctrl #(.IW(IW), .CNT_W(CW), .RUN_DIV(RD)) dut (
    .clock(clock), .reset(reset), .step_in(step_in), .run(run), .instr_in(instr_in),
    .W_En(W_En), .instr_q(instr_q), .step_cnt(step_cnt), .busy(busy),
    .hist_sel(hist_sel), .hist_out(hist_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Reference model: step_in is seen two edges late, a press is a rising level of that
  // delayed view; an accepted trigger yields capture one edge later, the pulse the edge
  // after, and the count/history update as the pulse ends.
  bit sh [3] = '{0, 0, 0};
  int age = 0, ph = -1;
  logic [IW-1:0] m_instr = '0;
  logic [IW-1:0] m_hist [4] = '{default: '0};
  logic [CW-1:0] m_cnt = '0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh = '{0, 0, 0};
      age = 0;
      ph = -1;
      m_instr = '0;
      m_cnt = '0;
      m_hist = '{default: '0};
    end else begin
      bit rise, tk, trg;
      rise = sh[1] && !sh[2];
      tk = run && (age % RD == RD - 1);
      trg = run ? tk : rise;
      if (ph < 0) ph = trg ? 0 : -1;
      else if (ph == 0) begin ph = 1; m_instr = instr_in; end
      else if (ph == 1) begin
        ph = 2;
        m_cnt = m_cnt + 1'b1;
        m_hist = '{m_instr, m_hist[0], m_hist[1], m_hist[2]};
      end else if (run || !sh[1]) ph = -1;
      age = run ? age + 1 : 0;
      sh[2] = sh[1];
      sh[1] = sh[0];
      sh[0] = step_in;
    end
  end
  always @(negedge clock) if (reset) begin
    check("m_wen", W_En, 32'(ph == 1));
    check("m_busy", busy, 32'(ph >= 0));
    check("m_instr", instr_q, m_instr);
    check("m_cnt", step_cnt, m_cnt);
`ifdef STEP_HIST_EN
    check("m_hist", hist_out, m_hist[hist_sel]);
`else
    check("m_hist", hist_out, 0);
`endif
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      ncyc++;
      if (W_En) begin pulses++; pt.push_back(ncyc); end
      #1;
    end
  endtask
  initial begin
    int lat, bf, t;
    cyc(3);
    check("rst_wen", W_En, 0);
    check("rst_busy", busy, 0);
    check("rst_instr", instr_q, 0);
    check("rst_cnt", step_cnt, 0);
    check("rst_hist", hist_out, 0);
    reset = 1;
    cyc(2);
    // manual step
    instr_in = 16'hA5C3;
    step_in = 1;
    pulses = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (W_En && lat == 0) lat = i;
    end
    check("latency", lat, 4);
    check("pulses1", pulses, 1);
    check("cnt1", step_cnt, 1);
    check("instr1", instr_q, 16'hA5C3);
    step_in = 0;
    bf = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (!busy && bf == 0) bf = i;
    end
    check("busy_fall", bf, 3);
    // long hold gives one pulse, then a second press
    pulses = 0;
    instr_in = 16'h1234;
    step_in = 1;
    cyc(1000);
    check("hold_pulses", pulses, 1);
    step_in = 0;
    cyc(5);
    instr_in = 16'h0F0F;
    step_in = 1;
    cyc(10);
    step_in = 0;
    cyc(5);
    check("cnt3", step_cnt, 3);
    check("instr_0f0f", instr_q, 16'h0F0F);
    // auto-run with toggling button
    pulses = 0;
    ncyc = 0;
    pt.delete();
    run = 1;
    for (int i = 0; i < 80; i++) begin
      step_in = 1'($urandom);
      instr_in = 16'($urandom);
      cyc(1);
    end
    step_in = 0;
    cyc(4);
    run = 0;
    cyc(4);
    check("run_pulses", pulses, 10);
    for (int i = 1; i < pt.size(); i++) check("run_gap", pt[i] - pt[i-1], RD);
    check("run_cnt", step_cnt, 13);
    // wrap
    run = 1;
    t = 0;
    while (step_cnt != 8'd255 && t < 4000) begin cyc(1); t++; end
    check("cnt255", step_cnt, 255);
    t = 0;
    while (step_cnt == 8'd255 && t < 40) begin cyc(1); t++; end
    check("wrap0", step_cnt, 0);
    // reset in the middle of a pulse
    t = 0;
    while (!W_En && t < 40) begin cyc(1); t++; end
    check("wen_seen", W_En, 1);
    reset = 0;
    #1;
    check("arst_wen", W_En, 0);
    check("arst_busy", busy, 0);
    check("arst_instr", instr_q, 0);
    check("arst_cnt", step_cnt, 0);
    run = 0;
    cyc(2);
    reset = 1;
    cyc(3);
    check("post_wen", W_En, 0);
    check("post_busy", busy, 0);
    check("post_cnt", step_cnt, 0);
    // history
    for (int v = 1; v <= 5; v++) begin
      instr_in = 16'(v);
      step_in = 1;
      cyc(8);
      step_in = 0;
      cyc(5);
    end
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
`ifdef STEP_HIST_EN
      check("hist", hist_out, 5 - s);
`else
      check("hist", hist_out, 0);
`endif
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) step_in = ~step_in;
      if ($urandom_range(150) == 0) run = ~run;
      instr_in = 16'($urandom);
      hist_sel = 2'($urandom);
      cyc(1);
    end
    run = 0;
    step_in = 0;
    cyc(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
